// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS datapath.
// Steps each instruction through fetch, decode, execute, memory and
// writeback and drives all datapath enables and mux selects.
//
// Optional feature macro: MEM_WAIT_EN
//   defined   -> FETCH, MEMRD and MEMWR hold until mem_ready=1
//   undefined -> mem_ready is ignored, every state lasts one cycle
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   opcode, funct       IR[31:26], IR[5:0] (funct only detects jr)
//   zero                ALU zero flag, used in BRANCH
//   mem_ready           memory handshake (MEM_WAIT_EN only)
//   PCWrite .. RegDst   single-bit datapath controls
//   PCSource, ALUSrcB   2-bit mux selects
//   ALUop               2-bit ALU control (00 add, 01 sub, 10 R-format)
//   pc_en               PCWrite | (PCWriteCond & zero)
//   illegal             one-cycle pulse on unsupported opcode in DECODE
//   state               current state, debug
module multicycle_control #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            ALUSrcA,
  output logic            RegWrite,
  output logic            RegDst,
  output logic [1:0]      PCSource,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUop,
  output logic            pc_en,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  typedef enum logic [ST_W-1:0] {
    FETCH   = 0,
    DECODE  = 1,
    MEMADDR = 2,
    MEMRD   = 3,
    MEMWB   = 4,
    MEMWR   = 5,
    EXEC    = 6,
    RWB     = 7,
    BRANCH  = 8,
    JUMP    = 9,
    ADDI_EX = 10,
    ADDI_WB = 11,
    JR      = 12
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] FN_JR   = 6'd8;

  state_t state_q, state_d, dec_state;
  logic   ready;

`ifdef MEM_WAIT_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // During reset the outputs are decoded as FETCH, then the write
  // enables are forced low, so the datapath sees stable selects.
  assign dec_state = reset ? FETCH : state_q;

  always_comb begin
    state_d     = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    illegal     = 1'b0;
    unique case (dec_state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = ready;
        PCWrite = ready;
        ALUSrcB = 2'b01;
        state_d = ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADDR;
          OP_R:         state_d = (funct == FN_JR) ? JR : EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        state_d = RWB;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
      end
      JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      default: state_d = FETCH;
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      illegal     = 1'b0;
    end
  end

  assign pc_en = PCWrite | (PCWriteCond & zero);
  assign state = reset ? '0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB, ALUop;
  logic       pc_en, illegal;
  logic [3:0] state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ST_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
    .pc_en(pc_en), .illegal(illegal), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned wr_cnt;
    reset = 1'b1; opcode = 6'd0; funct = 6'd32; zero = 1'b0; mem_ready = 1'b1;

    // reset, two cycles
    tick();
    check("rst_state", state, 0);
    check("rst_pcwrite", PCWrite, 0);
    check("rst_irwrite", IRWrite, 0);
    check("rst_memread", MemRead, 1);
    check("rst_alusrcb", ALUSrcB, 1);
    check("rst_pc_en", pc_en, 0);
    tick();
    check("rst_illegal", illegal, 0);
    check("rst_irwrite2", IRWrite, 0);
    reset = 1'b0;
    #1;
    check("fetch0_state", state, 0);
    check("fetch0_pcwrite", PCWrite, 1);
    check("fetch0_irwrite", IRWrite, 1);
    check("fetch0_pc_en", pc_en, 1);

    // R-format add
    opcode = 6'd0; funct = 6'd32;
    tick(); check("r_dec", state, 1); check("r_dec_srcb", ALUSrcB, 3);
    check("r_dec_irw", IRWrite, 0);
    tick(); check("r_exec", state, 6); check("r_exec_aluop", ALUop, 2);
    check("r_exec_srca", ALUSrcA, 1); check("r_exec_srcb", ALUSrcB, 0);
    tick(); check("r_rwb", state, 7); check("r_rwb_regwrite", RegWrite, 1);
    check("r_rwb_regdst", RegDst, 1); check("r_rwb_memtoreg", MemtoReg, 0);
    tick(); check("r_done", state, 0);

    // lw
    opcode = 6'd35;
    tick(); check("lw_dec", state, 1);
    tick(); check("lw_addr", state, 2); check("lw_addr_srcb", ALUSrcB, 2);
    check("lw_addr_srca", ALUSrcA, 1);
    tick(); check("lw_rd", state, 3); check("lw_rd_memread", MemRead, 1);
    check("lw_rd_iord", IorD, 1);
    tick(); check("lw_wb", state, 4); check("lw_wb_memtoreg", MemtoReg, 1);
    check("lw_wb_regwrite", RegWrite, 1); check("lw_wb_regdst", RegDst, 0);
    tick(); check("lw_done", state, 0);

    // sw
    opcode = 6'd43;
    wr_cnt = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (MemWrite) wr_cnt++;
      tick();
      if (i == 2) begin
        check("sw_wr", state, 5);
        check("sw_wr_iord", IorD, 1);
      end
    end
    check("sw_done", state, 0);
    check("sw_memwrite_once", wr_cnt, 1);

    // beq taken
    opcode = 6'd4; zero = 1'b1;
    tick(); check("beq1_dec", state, 1);
    tick(); check("beq1_br", state, 8); check("beq1_aluop", ALUop, 1);
    check("beq1_pcsrc", PCSource, 1); check("beq1_cond", PCWriteCond, 1);
    check("beq1_pcwrite", PCWrite, 0); check("beq1_pc_en", pc_en, 1);
    tick(); check("beq1_done", state, 0);

    // beq not taken
    zero = 1'b0;
    tick(); tick(); check("beq0_br", state, 8); check("beq0_pc_en", pc_en, 0);
    tick(); check("beq0_done", state, 0);

    // j
    opcode = 6'd2;
    tick(); tick(); check("j_state", state, 9); check("j_pcsrc", PCSource, 2);
    check("j_pcwrite", PCWrite, 1);
    tick(); check("j_done", state, 0);

    // jr
    opcode = 6'd0; funct = 6'd8;
    tick(); tick(); check("jr_state", state, 12); check("jr_pcsrc", PCSource, 3);
    check("jr_pc_en", pc_en, 1);
    tick(); check("jr_done", state, 0);

    // addi
    opcode = 6'd8;
    tick(); tick(); check("addi_ex", state, 10); check("addi_ex_srcb", ALUSrcB, 2);
    tick(); check("addi_wb", state, 11); check("addi_wb_regwrite", RegWrite, 1);
    check("addi_wb_regdst", RegDst, 0);
    tick(); check("addi_done", state, 0);

    // illegal opcode
    opcode = 6'd63;
    check("ill_fetch", illegal, 0);
    tick(); check("ill_dec", state, 1); check("ill_pulse", illegal, 1);
    tick(); check("ill_back", state, 0); check("ill_cleared", illegal, 0);

    // reset mid-lw aborts before writeback
    opcode = 6'd35;
    tick(); tick(); check("abort_addr", state, 2);
    reset = 1'b1; #1;
    check("abort_state", state, 0); check("abort_regwrite", RegWrite, 0);
    tick(); check("abort_after", state, 0); check("abort_regwrite2", RegWrite, 0);
    reset = 1'b0; #1;
    check("abort_fetch", PCWrite, 1);

`ifdef MEM_WAIT_EN
    // lw with waits in FETCH and MEMRD
    mem_ready = 1'b0; #1;
    check("mw_fetch_irw", IRWrite, 0); check("mw_fetch_pcw", PCWrite, 0);
    check("mw_fetch_rd", MemRead, 1);
    tick(); check("mw_fetch_hold", state, 0);
    mem_ready = 1'b1; #1;
    check("mw_fetch_pcw1", PCWrite, 1);
    tick(); check("mw_dec", state, 1);
    tick(); check("mw_addr", state, 2);
    mem_ready = 1'b0;
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      check("mw_rd_hold", state, 3); check("mw_rd_memread", MemRead, 1);
      if (i == 2) mem_ready = 1'b1;
      if (i < 2) tick();
    end
    check("mw_rd_last", state, 3);
    tick(); check("mw_wb", state, 4);
    tick(); check("mw_done", state, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
